modport_spram: RTL and testbench



---
 rtl/modport_spram_if.sv | 28 ++
 rtl/modport_spram.sv | 56 +++++
 tb/tb_modport_spram.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/modport_spram_if.sv
// modport_spram_if: single-port RAM bus bundle.
// master drives addr/wen/me/wdata and observes rdata; slave is the RAM side.
interface modport_spram_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wen;
  logic                  me;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output addr,
    output wen,
    output me,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wen,
    input  me,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/modport_spram.sv
// modport_spram: synchronous single-port RAM, registered read data.
// Ports: clk, reset (async active-low), bus (slave: addr/wen/me/wdata -> rdata).
module modport_spram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  modport_spram_if.slave   bus
);

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_WR,
    CMD_RD
  } cmd_e;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  cmd_e                  cmd;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    cmd = CMD_IDLE;
    unique case (1'b1)
      (!bus.me):           cmd = CMD_IDLE;
      (bus.me && bus.wen): cmd = CMD_WR;
      (bus.me && !bus.wen): cmd = CMD_RD;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (cmd == CMD_RD)
      rdata_d = mem[bus.addr];
  end

  // Storage has no reset; contents survive it.
  // Gating on reset drops a write at an edge where reset is low.
  always_ff @(posedge clk) begin
    if (reset && cmd == CMD_WR)
      mem[bus.addr] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata_q <= '0;
    else
      rdata_q <= rdata_d;
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_modport_spram.sv
// tb_modport_spram: directed table plus random traffic for modport_spram.
// Inputs driven #1 after posedge, rdata checked #1 after the edge.
module tb_modport_spram;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  modport_spram_if #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(64)
  ) bus ();

  modport_spram #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        me;
    logic        wen;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic me_i, input logic wen_i,
                       input logic [15:0] a, input logic [63:0] d);
    bus.me    = me_i;
    bus.wen   = wen_i;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  task automatic step(input logic me_i, input logic wen_i,
                      input logic [15:0] a, input logic [63:0] d,
                      input logic [63:0] exp, input string name);
    drive(me_i, wen_i, a, d);
    @(posedge clk);
    #1;
    check(name, bus.rdata, exp);
  endtask

  function automatic vec_t mk(input logic me_i, input logic wen_i,
                              input logic [15:0] a, input logic [63:0] d,
                              input logic [63:0] e, input string n);
    vec_t v;
    v.me = me_i; v.wen = wen_i; v.addr = a;
    v.wdata = d; v.exp = e; v.name = n;
    return v;
  endfunction

  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PA5  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] P5A  = 64'h5A5A_5A5A_5A5A_5A5A;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pool [16];
    logic [63:0] model [16];
    logic [15:0] written;
    logic [63:0] exp;
    logic [63:0] d;
    int k;
    int op;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 64'h0);
    repeat (2) @(posedge clk);

    // reset asserted mid-cycle: rdata clears without a clock edge
    #4 reset = 1'b0;
    #1 check("rst_async", bus.rdata, 64'h0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 16'h0000, 64'h0, 64'h0, "rst_hold");
    reset = 1'b1;
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 16'h0000, 64'h0, 64'h0, "rst_idle");

    vecs.push_back(mk(1, 1, 16'h0010, DEAD, 64'h0, "wr_hold"));
    vecs.push_back(mk(1, 0, 16'h0010, 64'h0, DEAD, "rd_0010"));
    vecs.push_back(mk(1, 1, 16'h0000, ONES, DEAD, "wr_0000"));
    vecs.push_back(mk(1, 1, 16'hFFFF, 64'h1, DEAD, "wr_ffff"));
    vecs.push_back(mk(1, 0, 16'hFFFF, 64'h0, 64'h1, "rd_ffff"));
    vecs.push_back(mk(1, 0, 16'h0000, 64'h0, ONES, "rd_0000"));
    vecs.push_back(mk(0, 1, 16'h0010, 64'h0, ONES, "me0_wen1"));
    vecs.push_back(mk(0, 0, 16'h0010, 64'h0, ONES, "me0_wen0"));
    vecs.push_back(mk(1, 0, 16'h0010, 64'h0, DEAD, "rd_gated"));
    vecs.push_back(mk(1, 1, 16'h1234, PA5, DEAD, "wr_a5"));
    vecs.push_back(mk(1, 1, 16'h1234, P5A, DEAD, "wr_5a"));
    vecs.push_back(mk(1, 0, 16'h1234, 64'h0, P5A, "rd_1234"));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 16'h1234, 64'h0, P5A, "idle_hold"));
    vecs.push_back(mk(1, 1, 16'h0100, 64'h1111, P5A, "wr_0100"));

    foreach (vecs[i])
      step(vecs[i].me, vecs[i].wen, vecs[i].addr,
           vecs[i].wdata, vecs[i].exp, vecs[i].name);

    // reset mid-cycle; a write during reset must be dropped
    #3 reset = 1'b0;
    #1 check("rst_mid", bus.rdata, 64'h0);
    step(1'b1, 1'b1, 16'h0100, 64'h2222, 64'h0, "rst_wr");
    step(1'b1, 1'b0, 16'h0100, 64'h0, 64'h0, "rst_rd");
    #3 reset = 1'b1;
    step(1'b1, 1'b0, 16'h0100, 64'h0, 64'h1111, "retain");
    step(1'b1, 1'b1, 16'h0200, 64'h0BAD_F00D, 64'h1111, "wr_0200");
    step(1'b1, 0, 16'h0200, 64'h0, 64'h0BAD_F00D, "rd_0200");

    // random traffic against a small model over a fixed address pool
    for (int i = 0; i < 16; i++)
      pool[i] = 16'($urandom_range(0, 65535));
    written = '0;
    exp = 64'h0BAD_F00D;
    for (int i = 0; i < 1000; i++) begin
      k  = $urandom_range(0, 15);
      op = $urandom_range(0, 2);
      if (op == 2 && !written[k])
        op = 1;
      d = {$urandom, $urandom};
      case (op)
        0: step(1'b0, 1'($urandom_range(0, 1)), pool[k], d,
                exp, "rnd_idle");
        1: begin
          step(1'b1, 1'b1, pool[k], d, exp, "rnd_wr");
          for (int j = 0; j < 16; j++)
            if (pool[j] == pool[k]) begin
              model[j] = d;
              written[j] = 1'b1;
            end
        end
        default: begin
          exp = model[k];
          step(1'b1, 1'b0, pool[k], d, exp, "rnd_rd");
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
